// File: rtl/rc5_engine.sv
// rc5_engine: RC5-W/r/b block cipher with on-chip key expansion, one round per clock.
// Define RC5_ENGINE_ERR_EN to add the err output that flags ignored requests.
module rc5_engine #(
    parameter int W          = 32,
    parameter int KEY_BYTES  = 16,
    parameter int MAX_ROUNDS = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_load,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [4:0]             num_rounds,
    input  logic                   encrypt,
    input  logic                   decrypt,
    input  logic [2*W-1:0]         d_in,
    output logic [2*W-1:0]         d_out,
    output logic                   done,
    output logic                   key_ready,
`ifdef RC5_ENGINE_ERR_EN
    output logic                   err,
`endif
    output logic                   busy
);
    // state | meaning
    // IDLE  | accepts requests     KINIT | S[i]=P+i*Q, one per cycle   KMIX | 3*max(t,c) mix steps
    // ENC   | encrypt rounds       DEC   | decrypt rounds              OUT  | publish d_out, pulse done
    typedef enum logic [2:0] {S_IDLE, S_KINIT, S_KMIX, S_ENC, S_DEC, S_OUT} state_t;

    localparam int T_MAX = 2 * (MAX_ROUNDS + 1);
    localparam int C     = (KEY_BYTES * 8 + W - 1) / W;
    localparam int LW    = $clog2(W);
    localparam int IW    = $clog2(T_MAX);
    localparam int JW    = (C > 1) ? $clog2(C) : 1;
    localparam int M_MAX = (T_MAX > C) ? T_MAX : C;
    localparam int KW    = $clog2(3 * M_MAX);
    localparam logic [W-1:0] P = (W == 16) ? W'(32'h0000_B7E1) : W'(32'hB7E1_5163);
    localparam logic [W-1:0] Q = (W == 16) ? W'(32'h0000_9E37) : W'(32'h9E37_79B9);

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] n);
        logic [2*W-1:0] d;
        d = {x, x} << n;
        return d[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LW-1:0] n);
        logic [2*W-1:0] d;
        d = {x, x} >> n;
        return d[W-1:0];
    endfunction

    state_t         r_state, w_next;
    logic [W-1:0]   r_s [T_MAX];
    logic [W-1:0]   r_l [C];
    logic [W-1:0]   r_a, r_b;
    logic [IW-1:0]  r_si, r_tm1;
    logic [JW-1:0]  r_lj;
    logic [KW-1:0]  r_kcnt, w_mix_last;
    logic [4:0]     r_reff, r_rnd, r_cnt, w_reff_in;
    logic           r_dec, r_kvalid, r_done;
    logic [2*W-1:0] r_dout;
    logic [C*W-1:0] w_key_pad;
    logic [IW-1:0]  w_idx_e, w_idx_o;
    logic [W-1:0]   w_ka, w_kab, w_kb, w_ea, w_eb, w_da, w_db;
    logic           w_idle, w_blk_ok;

    assign w_idle    = (r_state == S_IDLE);
    assign w_blk_ok  = (encrypt ^ decrypt) && r_kvalid;
    assign w_reff_in = (num_rounds > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : num_rounds;
    assign w_key_pad = (C*W)'(key);
    assign w_idx_e   = IW'({r_rnd, 1'b0});
    assign w_idx_o   = IW'({r_rnd, 1'b1});

    assign w_ka  = rotl(r_s[r_si] + r_a + r_b, LW'(3));
    assign w_kab = w_ka + r_b;
    assign w_kb  = rotl(r_l[r_lj] + w_kab, w_kab[LW-1:0]);

    assign w_ea = rotl(r_a ^ r_b, r_b[LW-1:0]) + r_s[w_idx_e];
    assign w_eb = rotl(r_b ^ w_ea, w_ea[LW-1:0]) + r_s[w_idx_o];
    assign w_db = rotr(r_b - r_s[w_idx_o], r_a[LW-1:0]) ^ r_a;
    assign w_da = rotr(r_a - r_s[w_idx_e], w_db[LW-1:0]) ^ w_db;

    // mix loop runs 3*max(t,c) times; counter is loaded with that count minus one
    always_comb begin
        w_mix_last = KW'(3 * C - 1);
        if (int'(r_tm1) + 1 > C) w_mix_last = KW'(3 * (int'(r_tm1) + 1) - 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (key_load)      w_next = S_KINIT;
                else if (w_blk_ok) w_next = (r_reff == 5'd0) ? S_OUT : (encrypt ? S_ENC : S_DEC);
            end
            S_KINIT:      if (r_si == r_tm1)   w_next = S_KMIX;
            S_KMIX:       if (r_kcnt == '0)    w_next = S_IDLE;
            S_ENC, S_DEC: if (r_cnt == 5'd1)   w_next = S_OUT;
            S_OUT:        w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_si     <= '0;
            r_tm1    <= '0;
            r_lj     <= '0;
            r_kcnt   <= '0;
            r_reff   <= '0;
            r_rnd    <= '0;
            r_cnt    <= '0;
            r_dec    <= 1'b0;
            r_kvalid <= 1'b0;
            r_done   <= 1'b0;
            r_dout   <= '0;
        end else begin
            r_done <= (r_state == S_OUT);
            case (r_state)
                S_IDLE: begin
                    if (key_load) begin
                        r_kvalid <= 1'b0;
                        r_reff   <= w_reff_in;
                        r_tm1    <= IW'({w_reff_in, 1'b1});
                        r_si     <= '0;
                        r_a      <= P;
                    end else if (w_blk_ok) begin
                        r_dec <= decrypt;
                        r_cnt <= r_reff;
                        r_rnd <= decrypt ? r_reff : 5'd1;
                        r_a   <= decrypt ? d_in[W-1:0]   : d_in[W-1:0] + r_s[0];
                        r_b   <= decrypt ? d_in[2*W-1:W] : d_in[2*W-1:W] + r_s[1];
                    end
                end
                S_KINIT: begin
                    if (r_si == r_tm1) begin
                        r_si   <= '0;
                        r_lj   <= '0;
                        r_a    <= '0;
                        r_b    <= '0;
                        r_kcnt <= w_mix_last;
                    end else begin
                        r_si <= r_si + 1'b1;
                        r_a  <= r_a + Q;
                    end
                end
                S_KMIX: begin
                    r_a    <= w_ka;
                    r_b    <= w_kb;
                    r_si   <= (r_si == r_tm1) ? '0 : r_si + 1'b1;
                    r_lj   <= (r_lj == JW'(C - 1)) ? '0 : r_lj + 1'b1;
                    r_kcnt <= r_kcnt - 1'b1;
                    if (r_kcnt == '0) r_kvalid <= 1'b1;
                end
                S_ENC: begin
                    r_a   <= w_ea;
                    r_b   <= w_eb;
                    r_rnd <= r_rnd + 5'd1;
                    r_cnt <= r_cnt - 5'd1;
                end
                S_DEC: begin
                    r_a   <= w_da;
                    r_b   <= w_db;
                    r_rnd <= r_rnd - 5'd1;
                    r_cnt <= r_cnt - 5'd1;
                end
                S_OUT: r_dout <= r_dec ? {r_b - r_s[1], r_a - r_s[0]} : {r_b, r_a};
                default: ;
            endcase
        end
    end

    // key tables survive reset; r_kvalid alone says whether they can be trusted
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE:  if (key_load) for (int j = 0; j < C; j++) r_l[j] <= w_key_pad[j*W +: W];
            S_KINIT: r_s[r_si] <= r_a;
            S_KMIX: begin
                r_s[r_si] <= w_ka;
                r_l[r_lj] <= w_kb;
            end
            default: ;
        endcase
    end

`ifdef RC5_ENGINE_ERR_EN
    logic r_err;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_err <= 1'b0;
        else      r_err <= w_idle ? (!key_load && (encrypt || decrypt) && !w_blk_ok)
                                  : (key_load || encrypt || decrypt);
    end
    assign err = r_err;
`endif

    assign d_out     = r_dout;
    assign done      = r_done;
    assign key_ready = w_idle && r_kvalid;
    assign busy      = !w_idle;
endmodule

// File: tb/tb_rc5_engine.sv
// tb_rc5_engine: vector table, corner sequences and random round-trips against a behavioural RC5-32 model.
// Expected blocks are queued when a request is driven and compared when done pulses.
module tb_rc5_engine;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_load = 1'b0;
    logic         encrypt = 1'b0;
    logic         decrypt = 1'b0;
    logic [127:0] key = '0;
    logic [4:0]   num_rounds = '0;
    logic [63:0]  d_in = '0;
    logic [63:0]  d_out;
    logic         done, key_ready, busy;
`ifdef RC5_ENGINE_ERR_EN
    logic         err;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] sb_q[$];
    logic [63:0] last_out = '0;
    logic [63:0] mon_exp;
    logic [31:0] m_s [42];
    int          cur_r = 0;

    typedef struct {
        logic [127:0] k;
        logic [4:0]   nr;
        bit           dec;
        logic [63:0]  din;
        logic [63:0]  exp;
    } vec_t;

    always #5 clk = ~clk;

    rc5_engine dut (
        .clk(clk), .rst(rst), .key_load(key_load), .key(key), .num_rounds(num_rounds),
        .encrypt(encrypt), .decrypt(decrypt), .d_in(d_in), .d_out(d_out), .done(done),
        .key_ready(key_ready),
`ifdef RC5_ENGINE_ERR_EN
        .err(err),
`endif
        .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input logic [31:0] s);
        int n;
        n = int'(s[4:0]);
        if (n == 0) return x;
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input logic [31:0] s);
        int n;
        n = int'(s[4:0]);
        if (n == 0) return x;
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic int clamp_r(input logic [4:0] nr);
        return (nr > 5'd20) ? 20 : int'(nr);
    endfunction

    task automatic model_expand(input logic [127:0] k, input int r);
        logic [31:0] l [4];
        logic [31:0] a, b;
        int t, i, j;
        t = 2 * (r + 1);
        for (int q = 0; q < 4; q++) l[q] = k[32*q +: 32];
        m_s[0] = 32'hB7E15163;
        for (int q = 1; q < t; q++) m_s[q] = m_s[q-1] + 32'h9E3779B9;
        a = '0; b = '0; i = 0; j = 0;
        for (int s = 0; s < 3 * ((t > 4) ? t : 4); s++) begin
            a = rol(m_s[i] + a + b, 32'd3);
            m_s[i] = a;
            b = rol(l[j] + a + b, a + b);
            l[j] = b;
            i = (i + 1) % t;
            j = (j + 1) % 4;
        end
    endtask

    function automatic logic [63:0] model_enc(input logic [63:0] d, input int r);
        logic [31:0] a, b;
        a = d[31:0] + m_s[0];
        b = d[63:32] + m_s[1];
        for (int i = 1; i <= r; i++) begin
            a = rol(a ^ b, b) + m_s[2*i];
            b = rol(b ^ a, a) + m_s[2*i+1];
        end
        return {b, a};
    endfunction

    function automatic logic [63:0] model_dec(input logic [63:0] d, input int r);
        logic [31:0] a, b;
        a = d[31:0];
        b = d[63:32];
        for (int i = r; i >= 1; i--) begin
            b = ror(b - m_s[2*i+1], a) ^ a;
            a = ror(a - m_s[2*i], b) ^ b;
        end
        return {b - m_s[1], a - m_s[0]};
    endfunction

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_without_request: got done=1, expected done=0 (t=%0t)", $time);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("d_out", d_out, mon_exp);
                last_out = mon_exp;
            end
        end
    end

    task automatic key_load_seq(input logic [127:0] k, input logic [4:0] nr);
        int r, t, n_exp, n;
        r = clamp_r(nr);
        t = 2 * (r + 1);
        n_exp = t + 3 * ((t > 4) ? t : 4);
        @(negedge clk);
        key = k; num_rounds = nr; key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        n = 0;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                chk("key_ready_drop", key_ready, 0);
                chk("busy_in_kexp", busy, 1);
            end
            if (key_ready === 1'b1) break;
        end
        chk("key_ready_latency", n, n_exp);
        model_expand(k, r);
        cur_r = r;
    endtask

    task automatic start_block(input bit dec, input logic [63:0] din, input logic [63:0] exp);
        @(negedge clk);
        d_in = din; encrypt = ~dec; decrypt = dec;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        encrypt = 1'b0; decrypt = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int n_exp);
        int n;
        n = n0;
        while (n < 64) begin
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done within %0d edges, expected at edge %0d", n, n_exp);
            sb_q.delete();
        end else begin
            chk("done_latency", n, n_exp);
            @(posedge clk); #1;
            chk("done_width", done, 0);
        end
    endtask

    task automatic run_block(input bit dec, input logic [63:0] din, input logic [63:0] exp);
        start_block(dec, din, exp);
        wait_done(0, cur_r + 1);
    endtask

    task automatic try_ignored_encrypt(input string name);
        @(negedge clk);
        d_in = 64'h0123_4567_89AB_CDEF; encrypt = 1'b1;
        @(posedge clk); #1;
        encrypt = 1'b0;
        chk({name, "_busy"}, busy, 0);
        repeat (15) @(posedge clk);
        #1;
        chk({name, "_dout"}, d_out, 0);
        chk({name, "_key_ready"}, key_ready, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         vecs[6];
        logic [127:0] k_a, k_b, rk, cur_k;
        logic [4:0]   cur_nr;
        logic [63:0]  din, ct;
        int           nr_list[5];

        nr_list = '{0, 1, 12, 20, 31};
        k_a = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        k_b = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
        vecs[0] = '{128'h0, 5'd12, 1'b0, 64'h0, 64'h6D8F4B15_EEDBA521};
        vecs[1] = '{128'h0, 5'd12, 1'b1, 64'h6D8F4B15_EEDBA521, 64'h0};
        vecs[2] = '{k_a, 5'd12, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0};
        vecs[3] = '{k_a, 5'd0,  1'b0, 64'hFFFF_0000_1234_5678, 64'h0};
        vecs[4] = '{k_a, 5'd31, 1'b0, 64'hA5A5_5A5A_C3C3_3C3C, 64'h0};
        vecs[5] = '{k_a, 5'd1,  1'b1, 64'h1357_9BDF_2468_ACE0, 64'h0};
        for (int i = 2; i < 6; i++) begin
            model_expand(vecs[i].k, clamp_r(vecs[i].nr));
            vecs[i].exp = vecs[i].dec ? model_dec(vecs[i].din, clamp_r(vecs[i].nr))
                                      : model_enc(vecs[i].din, clamp_r(vecs[i].nr));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", d_out, 0);
        chk("rst_done", done, 0);
        chk("rst_key_ready", key_ready, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;

        try_ignored_encrypt("enc_before_key");

        cur_k = '0;
        cur_nr = '0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || vecs[i].k != cur_k || vecs[i].nr != cur_nr) begin
                key_load_seq(vecs[i].k, vecs[i].nr);
                cur_k = vecs[i].k;
                cur_nr = vecs[i].nr;
            end
            run_block(vecs[i].dec, vecs[i].din, vecs[i].exp);
        end

        key_load_seq(k_a, 5'd12);
        din = 64'h0BAD_CAFE_DEAD_BEEF;
        run_block(1'b0, din, model_enc(din, cur_r));

        @(negedge clk);
        d_in = 64'hFEED_FACE_0000_0001; encrypt = 1'b1; decrypt = 1'b1;
        @(posedge clk); #1;
        encrypt = 1'b0; decrypt = 1'b0;
        chk("both_busy", busy, 0);
        chk("both_key_ready", key_ready, 1);
`ifdef RC5_ENGINE_ERR_EN
        chk("both_err", err, 1);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("both_dout", d_out, last_out);

        din = 64'h7777_8888_9999_AAAA;
        start_block(1'b0, din, model_enc(din, cur_r));
        @(posedge clk); #1;
        d_in = 64'h1111_2222_3333_4444; encrypt = 1'b1;
        @(posedge clk); #1;
        encrypt = 1'b0;
        wait_done(2, cur_r + 1);
        repeat (cur_r + 4) @(posedge clk);
        #1;
        chk("busy_req_idle", busy, 0);
        chk("busy_req_result", d_out, model_enc(din, cur_r));

        din = 64'hCAFE_BABE_0BAD_F00D;
        start_block(1'b0, din, model_enc(din, cur_r));
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        sb_q.delete();
        chk("rst_enc_dout", d_out, 0);
        chk("rst_enc_done", done, 0);
        chk("rst_enc_busy", busy, 0);
        chk("rst_enc_key_ready", key_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        try_ignored_encrypt("enc_after_rst");

        key_load_seq(k_b, 5'd12);
        din = 64'h5555_AAAA_3333_CCCC;
        run_block(1'b0, din, model_enc(din, cur_r));
        @(negedge clk);
        key = k_a; num_rounds = 5'd12; key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        repeat (40) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_kmix_busy", busy, 0);
        chk("rst_kmix_key_ready", key_ready, 0);
        chk("rst_kmix_dout", d_out, 0);
        chk("rst_kmix_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        try_ignored_encrypt("enc_after_kmix_rst");
        key_load_seq(128'h0, 5'd12);
        run_block(1'b0, 64'h0, 64'h6D8F4B15_EEDBA521);

        for (int kk = 0; kk < 20; kk++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            key_load_seq(rk, 5'(nr_list[kk % 5]));
            for (int b = 0; b < 50; b++) begin
                din = {$urandom, $urandom};
                ct = model_enc(din, cur_r);
                run_block(1'b0, din, ct);
                run_block(1'b1, ct, din);
            end
        end

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rc5_engine.md
RC5_ENGINE -- requirements
Module: rc5_engine

Interface
REQ-001 SHALL have parameter W, default 32, meaning word width in bits; legal values 16 and 32; block is 2W bits.
REQ-002 SHALL have parameter KEY_BYTES, default 16, meaning secret key length in bytes (1..32).
REQ-003 SHALL have parameter MAX_ROUNDS, default 20, meaning largest supported round count r (1..31); S-table depth is 2*(MAX_ROUNDS+1).
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, meaning asynchronous active-low reset.
REQ-006 SHALL have port key_load, input, 1 bit, meaning the request to start key expansion using key and num_rounds.
REQ-007 SHALL have port key, input, 8*KEY_BYTES bits, meaning the secret key; byte k is key[8k+7:8k].
REQ-008 SHALL have port num_rounds, input, 5 bits, meaning round count r, sampled only on key_load acceptance.
REQ-009 SHALL have port encrypt, input, 1 bit, meaning the encrypt-block request.
REQ-010 SHALL have port decrypt, input, 1 bit, meaning the decrypt-block request.
REQ-011 SHALL have port d_in, input, 2W bits, meaning the input block; A = d_in[W-1:0], B = d_in[2W-1:W].
REQ-012 SHALL have port d_out, output, 2W bits, meaning the result block, with the same packing as d_in, held until the next result.
REQ-013 SHALL have port done, output, 1 bit, meaning a one-cycle pulse marking d_out valid.
REQ-014 SHALL have port key_ready, output, 1 bit, meaning the expanded key is valid and the engine is idle.
REQ-015 SHALL have port busy, output, 1 bit, meaning the FSM is not in IDLE.

Function
REQ-016 SHALL implement states IDLE, KINIT, KMIX, ENC, DEC and OUT; IDLE is the only state that accepts requests.
REQ-017 SHALL apply request priority in IDLE as key_load first, then encrypt xor decrypt; encrypt and decrypt both high in the same cycle SHALL be ignored.
REQ-018 SHALL ignore encrypt/decrypt when key_ready=0, and SHALL ignore all requests while busy=1.
REQ-019 SHALL, on key_load, latch r_eff = min(num_rounds, MAX_ROUNDS), latch L[] from key (little-endian, zero-padded), and set t = 2*(r_eff+1) and c = max(1, ceil(KEY_BYTES*8/W)).
REQ-020 SHALL, in KINIT, write one S entry per cycle (t cycles): S[0]=P, S[i]=S[i-1]+Q mod 2^W; P/Q are 0xB7E1/0x9E37 for W=16 and 0xB7E15163/0x9E3779B9 for W=32.
REQ-021 SHALL, in KMIX, perform 3*max(t,c) iterations at one per cycle: A=S[i]=(S[i]+A+B)<<<3, B=L[j]=(L[j]+A+B)<<<(A+B), with i mod t and j mod c.
REQ-022 SHALL drop key_ready the cycle after key_load acceptance and reassert it exactly t+3*max(t,c) edges after the accepting edge (r=12, W=32, 16 bytes: 104 edges).
REQ-023 SHALL reduce all rotate amounts to their low log2(W) bits, and SHALL perform all addition and subtraction mod 2^W.
REQ-024 SHALL, on the encrypt accepting edge 0, load A=d_in_A+S[0] and B=d_in_B+S[1]; on edges 1..r_eff, per edge: A=((A^B)<<<B)+S[2i], B=((B^A)<<<A)+S[2i+1].
REQ-025 SHALL, on the decrypt accepting edge 0, load A and B raw; on edges 1..r_eff, with i descending r_eff..1: B=((B-S[2i+1])>>>A)^A, A=((A-S[2i])>>>B)^B; then A-=S[0], B-=S[1].
REQ-026 SHALL update d_out and pulse done on edge r_eff+1 after acceptance, and SHALL return to IDLE on the same edge.
REQ-027 SHALL, for r_eff=0, produce the whitened result on edge 1.
REQ-028 SHALL keep done low at all times other than the REQ-026 pulse.

Reset
REQ-029 SHALL, on rst low at any time including mid-key-expansion or mid-block, immediately force IDLE with d_out=0, done=0, key_ready=0 and busy=0.
REQ-030 SHALL NOT clear the S and L arrays on reset; key_ready=0 marks them invalid until the next completed key_load.

Configuration
REQ-031 SHALL, when macro RC5_ENGINE_ERR_EN is defined, add output err (1 bit) pulsing high for one cycle on any ignored request: both encrypt and decrypt, a request with key_ready=0 in IDLE, or any request while busy.
REQ-032 SHALL, when RC5_ENGINE_ERR_EN is undefined, omit port err and ignore such requests silently, with all other behaviour identical.

Verification
REQ-033 SHALL cover: W=32, KEY_BYTES=16, key=0, num_rounds=12, then encrypt d_in=0 -> key_ready after 104 edges; done 13 edges after accept with d_out A=0xEEDBA521, B=0x6D8F4B15.
REQ-034 SHALL cover: decrypt of the REQ-033 output -> d_out=0 after 13 edges; encrypt/decrypt round-trip on 1000 random blocks and keys with r in {0,1,12,20,31 clamped to 20} -> identity.
REQ-035 SHALL cover: encrypt and decrypt both high in IDLE -> no state change, no done, err pulse when RC5_ENGINE_ERR_EN is defined.
REQ-036 SHALL cover: encrypt pulsed while ENC is running, and encrypt issued before any key_load -> ignored, with the original result unchanged.
REQ-037 SHALL cover: rst low at round 5 of ENC and during KMIX -> outputs zero asynchronously, key_ready=0, a later encrypt is ignored until key_load completes.
